// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding and counter width.
package dmem_arb_pkg;

    // Arbiter FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RDATA = 1'b1;

    // Width of the starvation counter
    localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    // Clear wins over increment; increment stops at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != {W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the CPU MEM stage (always wins, zero
// latency) and one peripheral using a req/ack handshake with registered read
// return. Tracks how long the peripheral has been kept waiting.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_wren,
    input  logic              cpu_active,
    output logic [DATA_W-1:0] cpu_q,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    output logic              per_ack,
    output logic [DATA_W-1:0] per_rdata,
    output logic              per_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [CNT_W-1:0]  starve_count,
    output logic              starve_flag
);

    localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_MAX);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              issue;

    // The peripheral only gets a cycle the CPU leaves free, and never while a
    // read return is still in flight. Held off during reset so nothing is acked.
    assign issue = ~reset & (state_q == ST_IDLE) & per_req & ~cpu_active;

    // Memory port mux; an idle CPU never writes, whatever cpu_wren says
    always_comb begin
        mem_addr = cpu_addr;
        mem_data = cpu_data;
        mem_wren = 1'b0;
        if (cpu_active) begin
            mem_wren = cpu_wren;
        end else if (issue) begin
            mem_addr = per_addr;
            mem_data = per_wdata;
            mem_wren = per_we;
        end
    end

    // Reads park in RDATA for one cycle while dmem produces the data;
    // writes complete at the issuing edge so the FSM stays in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (issue && !per_we) state_d = ST_RDATA;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM and read-return registers; mem_q in RDATA already holds the
    // peripheral's data, regardless of what the CPU drives this cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (state_q == ST_RDATA);
            if (state_q == ST_RDATA)
                rdata_q <= mem_q;
        end
    end

    sat_counter #(.W(CNT_W)) u_starve (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (per_req & ~issue),
        .clr_i   (~per_req | issue),
        .count_o (starve_count)
    );

    assign per_ack     = issue;
    assign per_rdata   = rdata_q;
    assign per_rvalid  = rvalid_q;
    assign cpu_q       = mem_q;
    assign starve_flag = (starve_count >= STARVE_TH);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a scoreboard for read returns.
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_data = '0;
    logic        cpu_wren = 1'b0, cpu_active = 1'b0;
    logic [31:0] cpu_q;
    logic        per_req = 1'b0, per_we = 1'b0;
    logic [31:0] per_addr = '0, per_wdata = '0;
    logic        per_ack;
    logic [31:0] per_rdata;
    logic        per_rvalid;
    logic [31:0] mem_addr, mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = '0;
    logic [7:0]  starve_count;
    logic        starve_flag;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
        .cpu_active(cpu_active), .cpu_q(cpu_q),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata),
        .per_rvalid(per_rvalid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q),
        .starve_count(starve_count), .starve_flag(starve_flag)
    );

    // Synchronous-read data memory (read returns old data on a same-edge write)
    logic [31:0] mem [256];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_addr[7:0]] <= mem_data;
        mem_q <= mem[mem_addr[7:0]];
    end

    // Reference model state
    typedef struct { logic [31:0] data; int cyc; } ret_t;
    ret_t        rq[$];
    logic [31:0] ref_mem [256];
    int          cnt_m = 0;
    bit          busy_m = 1'b0;   // cycle right after a read ack: no issue allowed
    bit          last_ack = 1'b0;
    int          cyc = 0;
    int          total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational/registered outputs
    // against the model, then advance the model across the next edge.
    task automatic cycle(input bit rst, input bit ca, input bit cw,
                         input logic [31:0] caddr, input logic [31:0] cdata,
                         input bit preq, input bit pwe,
                         input logic [31:0] paddr, input logic [31:0] pwdata);
        bit ea;
        @(posedge clock);
        cyc++;
        #1;
        reset = rst; cpu_active = ca; cpu_wren = cw; cpu_addr = caddr; cpu_data = cdata;
        per_req = preq; per_we = pwe; per_addr = paddr; per_wdata = pwdata;
        #2;
        if (rst) begin
            cnt_m = 0; busy_m = 1'b0; rq.delete();
        end
        ea = !rst && preq && !ca && !busy_m;
        chk("per_ack",      64'(per_ack),      64'(ea));
        chk("mem_addr",     64'(mem_addr),     64'(ea ? paddr : caddr));
        chk("mem_data",     64'(mem_data),     64'(ea ? pwdata : cdata));
        chk("mem_wren",     64'(mem_wren),     64'(ca ? cw : (ea & pwe)));
        chk("cpu_q",        64'(cpu_q),        64'(mem_q));
        chk("starve_count", 64'(starve_count), 64'(cnt_m));
        chk("starve_flag",  64'(starve_flag),  64'(cnt_m >= SM));
        last_ack = ea;
        if (!rst) begin
            if (ea && !pwe) begin
                rq.push_back(ret_t'{ref_mem[paddr[7:0]], cyc + 2});
                busy_m = 1'b1;
            end else begin
                busy_m = 1'b0;
            end
            if (ca && cw) ref_mem[caddr[7:0]] = cdata;
            else if (ea && pwe) ref_mem[paddr[7:0]] = pwdata;
            cnt_m = (preq && !ea) ? ((cnt_m >= 255) ? 255 : cnt_m + 1) : 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    // Monitor: checks every read return and the hold/reset behaviour of per_rdata
    initial begin
        logic [31:0] hold;
        ret_t e;
        hold = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold = '0;
                chk("rst_rvalid", 64'(per_rvalid), 64'(0));
                chk("rst_rdata",  64'(per_rdata),  64'(0));
            end else if (per_rvalid) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_rvalid cyc=%0d got=1 exp=0", cyc);
                end else begin
                    e = rq.pop_front();
                    chk("rdata",    64'(per_rdata), 64'(e.data));
                    chk("ret_cyc",  64'(cyc),       64'(e.cyc));
                    hold = e.data;
                end
            end else begin
                chk("rdata_hold", 64'(per_rdata), 64'(hold));
                if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                    total++; bad++;
                    $display("FAIL missing_rvalid cyc=%0d got=0 exp=1", cyc);
                    void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        bit          preq_r, pwe_r, ca, cw;
        logic [31:0] paddr_r, pwdata_r, caddr, cdata;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        #1 reset = 1'b1;

        // Reset: mem_wren follows cpu_wren & cpu_active, no ack
        cycle(1, 1, 1, 32'h40, 32'hDEAD, 1, 0, 32'h10, 32'h5);
        cycle(1, 0, 1, 32'h41, 32'hBEEF, 1, 1, 32'h11, 32'h6);
        cycle(1, 1, 0, 32'h42, 32'h1111, 0, 0, 32'h0,  32'h0);

        // CPU passthrough with a competing peripheral request
        cycle(0, 1, 1, 32'h40, 32'hDEAD, 1, 0, 32'h10, 32'h0);
        // Preload mem[0x10] via CPU store; dropping per_req clears the counter
        cycle(0, 1, 1, 32'h10, 32'h1234, 0, 0, 32'h0, 32'h0);

        // Peripheral read, then a second read held during the RDATA cycle
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
        idle(3);

        // Read with the CPU active in N+1
        cycle(0, 0, 0, 32'h0,  32'h0,    1, 0, 32'h10, 32'h0);
        cycle(0, 1, 1, 32'h50, 32'h7777, 0, 0, 32'h0,  32'h0);
        idle(3);

        // Write burst to 0x20..0x23
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h20 + i, 32'hA0 + i);
        idle(1);
        for (int i = 0; i < 4; i++)
            chk("burst_mem", 64'(mem[8'h20 + i]), 64'(32'hA0 + i));

        // Contention for 6 cycles, then release
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 0, 32'h60, 32'h0, 1, 0, 32'h21, 32'h0);
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h21, 32'h0);
        idle(3);

        // Saturation
        for (int i = 0; i < 300; i++)
            cycle(0, 1, 0, 32'h60, 32'h0, 1, 1, 32'h30, 32'h99);
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'h99);
        idle(2);

        // Reset asserted during RDATA drops the pending return
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h22, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,  32'h0);
        idle(4);

        // Randomized traffic
        preq_r = 1'b0; pwe_r = 1'b0; paddr_r = '0; pwdata_r = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!preq_r || last_ack) begin
                preq_r   = ($urandom % 3) != 0;
                pwe_r    = 1'($urandom % 2);
                paddr_r  = $urandom % 256;
                pwdata_r = $urandom;
            end else if ($urandom % 20 == 0) begin
                preq_r = 1'b0;
            end
            ca    = 1'($urandom % 2);
            cw    = 1'($urandom % 2);
            caddr = $urandom % 256;
            cdata = $urandom;
            cycle(0, ca, cw, caddr, cdata, preq_r, pwe_r, paddr_r, pwdata_r);
        end
        idle(4);
        chk("queue_empty", 64'(rq.size()), 64'(0));
        for (int i = 0; i < 256; i++)
            chk("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the pipelined processor's MEM stage and one peripheral requester, such as a display/sprite reader or game-state logger. The processor has no memory-stall input, so its port always wins with zero added latency. The peripheral gets idle memory cycles through a req/ack handshake with registered read return. The block sits in the wrapper between the processor's dmem outputs and the dmem instance, and reports peripheral starvation.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 64, wait-cycle count at which starve_flag asserts; legal range 1..255

Ports:
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns all state to reset values
- cpu_addr  in  ADDR_W  processor MEM-stage address
- cpu_data  in  DATA_W  processor store data
- cpu_wren  in  1  processor store enable
- cpu_active  in  1  MEM stage holds a lw or sw this cycle
- cpu_q  out  DATA_W  memory read data to processor; combinational passthrough of mem_q
- per_req  in  1  peripheral request; held high until per_ack
- per_we  in  1  1 = write, 0 = read; sampled with per_req
- per_addr  in  ADDR_W  peripheral address
- per_wdata  in  DATA_W  peripheral write data
- per_ack  out  1  one-cycle pulse: request issued to memory this cycle
- per_rdata  out  DATA_W  registered read data
- per_rvalid  out  1  one-cycle pulse: per_rdata valid
- mem_addr  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem write data
- mem_wren  out  1  to dmem write enable
- mem_q  in  DATA_W  from dmem; synchronous read, valid the cycle after the address is sampled
- starve_count  out  8  saturating count of consecutive un-acked per_req cycles
- starve_flag  out  1  starve_count >= STARVE_MAX

## Operation
- FSM states: IDLE, RDATA. Encoding lives in the package.
- Memory mux is combinational:
  - If cpu_active: mem_* = cpu_*.
  - Else, if the issue condition holds: mem_addr = per_addr, mem_data = per_wdata, mem_wren = per_we.
  - Otherwise: mem_addr = cpu_addr, mem_data = cpu_data, mem_wren = 0.
- Issue condition: state == IDLE & per_req & ~cpu_active. When it holds, per_ack = 1 the same cycle (combinational).
- IDLE transitions:
  - Issue of a read goes to RDATA.
  - Issue of a write stays in IDLE, so back-to-back writes run at one per free cycle.
- RDATA: no new peripheral issue. At the rising edge ending RDATA, per_rdata <= mem_q, per_rvalid <= 1 for one cycle, and state goes to IDLE.
- cpu_active during RDATA does not disturb the capture, because mem_q already reflects the peripheral address sampled at the previous edge.
- per_rdata holds its value until the next read return.
- Starvation counter:
  - Increments each cycle per_req & ~per_ack, saturating at 255.
  - Clears to 0 on any cycle per_ack = 1, or when per_req = 0.
- cpu_wren is ignored when cpu_active = 0.

## Timing
- Reset values: state IDLE, per_rdata 0, per_rvalid 0, starve_count 0, starve_flag 0.
- Combinational outputs follow the inputs: per_ack = 0 and mem_wren = cpu_wren & cpu_active.
- Processor latency: zero; cpu_* pass through with no added cycle.
- Peripheral read: ack in cycle N, memory samples at the edge ending N, per_rvalid high in cycle N+2. Earliest next ack is cycle N+2.
- Peripheral write: ack in cycle N, memory written at the edge ending N. Next ack is possible in N+1.
- Simultaneous cpu_active and per_req in IDLE: CPU wins, no ack, counter increments.
- Reset asserted in RDATA: the pending per_rvalid is dropped, and the return is never issued after reset deasserts.
- per_req dropped before ack: no issue, counter clears. Dropping per_req after ack is legal.

## Structure
- Package dmem_arb_pkg holds:
  - State encoding constants: ST_IDLE = 1'b0, ST_RDATA = 1'b1.
  - Counter width constant: 8.
- One sub-module, sat_counter: 8-bit saturating counter with increment, clear and async reset, instantiated for starve_count.
- All other logic is inline.

## Test plan
- Reset check: with reset high, all registered outputs are 0 and mem_wren follows cpu_wren & cpu_active. Assert reset mid-RDATA and confirm no per_rvalid appears.
- CPU passthrough: cpu_active=1, cpu_addr=0x40, cpu_wren=1, cpu_data=0xDEAD gives mem_addr=0x40, mem_wren=1, mem_data=0xDEAD the same cycle, and per_ack=0 despite per_req=1.
- Peripheral read: preload mem[0x10]=0x1234; per_req=1, per_we=0, per_addr=0x10 with cpu idle gives per_ack in cycle N, per_rvalid=1 and per_rdata=0x1234 in N+2. Repeat with cpu_active=1 in N+1; the result is the same.
- Write burst: four per writes to 0x20..0x23 with cpu idle give four consecutive acks and memory contents match.
- Contention/starvation with STARVE_MAX=4:
  - Hold cpu_active=1 for 6 cycles with per_req=1.
  - starve_count goes 1..6 and starve_flag rises in cycle 4.
  - Dropping cpu_active gives ack, count 0 and flag 0 the next cycle.
- Saturation: hold contention 300 cycles; starve_count stays at 255.
